// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller: FSM state encoding,
// mcause layout and the helper that builds an interrupt cause word.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTER = 2'd1,
        BUSY  = 2'd2,
        EXIT  = 2'd3
    } irq_state_t;

    localparam int MCAUSE_IRQ_BIT = 31;
    localparam int MAX_IRQ        = 32;
    localparam int IDX_W          = $clog2(MAX_IRQ);

    function automatic logic [31:0] make_mcause(input logic [IDX_W-1:0] idx);
        logic [31:0] cause;
        cause                 = '0;
        cause[MCAUSE_IRQ_BIT] = 1'b1;
        cause[IDX_W-1:0]      = idx;
        return cause;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: reports the lowest set bit of vector_i.
// valid_o is low (and index_o zero) when no bit is set.
module irq_prio_enc #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 5
) (
    input  logic [WIDTH-1:0] vector_i,
    output logic [IDX_W-1:0] index_o,
    output logic             valid_o
);

    // Scan from the top so the last hit, i.e. the lowest index, wins.
    always_comb begin
        index_o = '0;
        valid_o = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vector_i[i]) begin
                index_o = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Non-nesting interrupt controller: picks the lowest enabled pending line,
// strobes trap entry, waits for mret, then acknowledges the serviced device.
// Define IRQ_EDGE_EN for edge-triggered pending latches; default is level mode.
module interrupt_controller
    import irq_pkg::*;
#(
    parameter int NUM_IRQ = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_IRQ-1:0] irq_req_i,
    input  logic [31:0]        mie_i,
    input  logic               irq_fin_i,
    output logic               irq_o,
    output logic [31:0]        mcause_o,
    output logic [NUM_IRQ-1:0] irq_ack_o
);

    irq_state_t         state_q;
    logic [IDX_W-1:0]   sel_q;
    logic               irq_q;
    logic [31:0]        mcause_q;
    logic [NUM_IRQ-1:0] ack_q;

    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] eligible;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_valid;
    logic               unused_ok;

    assign unused_ok = ^mie_i;

`ifdef IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;

    assign rise = irq_req_i & ~prev_q;
    assign clr  = (state_q == EXIT) ? (NUM_IRQ'(1) << sel_q) : '0;

    // A fresh edge is visible to selection in the same cycle it is seen,
    // and a rise on the serviced line during EXIT survives the clear.
    assign pending = pend_q | rise;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= '0;
            pend_q <= '0;
        end else begin
            prev_q <= irq_req_i;
            pend_q <= (pend_q & ~clr) | rise;
        end
    end
`else
    assign pending = irq_req_i;
`endif

    assign eligible = pending & mie_i[NUM_IRQ-1:0];

    irq_prio_enc #(
        .WIDTH (NUM_IRQ),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .vector_i (eligible),
        .index_o  (enc_idx),
        .valid_o  (enc_valid)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            irq_q    <= 1'b0;
            mcause_q <= '0;
            ack_q    <= '0;
        end else begin
            irq_q <= 1'b0;
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (enc_valid) begin
                        sel_q    <= enc_idx;
                        mcause_q <= make_mcause(enc_idx);
                        irq_q    <= 1'b1;
                        state_q  <= ENTER;
                    end
                end
                ENTER: state_q <= BUSY;
                BUSY: begin
                    if (irq_fin_i) begin
                        ack_q   <= NUM_IRQ'(1) << sel_q;
                        state_q <= EXIT;
                    end
                end
                EXIT:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign irq_o     = irq_q;
    assign mcause_o  = mcause_q;
    assign irq_ack_o = ack_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: a vector table, directed corner
// sequences and randomized traffic, all compared against a service-level model.
module tb_interrupt_controller;

    localparam int N = 16;

    logic          clk_i     = 1'b0;
    logic          rst_ni    = 1'b0;
    logic [N-1:0]  irq_req_i = '0;
    logic [31:0]   mie_i     = '0;
    logic          irq_fin_i = 1'b0;
    logic          irq_o;
    logic [31:0]   mcause_o;
    logic [N-1:0]  irq_ack_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    interrupt_controller #(.NUM_IRQ(N)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .irq_req_i (irq_req_i),
        .mie_i     (mie_i),
        .irq_fin_i (irq_fin_i),
        .irq_o     (irq_o),
        .mcause_o  (mcause_o),
        .irq_ack_o (irq_ack_o)
    );

    // Service-level reference: one service record plus the edge-latched pending set.
    bit           m_active;
    bit           m_ending;
    int           m_line;
    int           m_age;
    logic [31:0]  m_mcause;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_prev;

    task automatic model_reset();
        m_active = 0;
        m_ending = 0;
        m_line   = 0;
        m_age    = 0;
        m_mcause = '0;
        m_pend   = '0;
        m_prev   = '0;
    endtask

    task automatic model_edge();
        logic [N-1:0] rise, visible, elig, clr;
        rise = irq_req_i & ~m_prev;
        clr  = '0;
`ifdef IRQ_EDGE_EN
        visible = m_pend | rise;
`else
        visible = irq_req_i;
`endif
        elig = visible & mie_i[N-1:0];
        if (m_ending) begin
            clr[m_line] = 1'b1;
            m_active    = 0;
            m_ending    = 0;
        end else if (m_active) begin
            if (m_age >= 1 && irq_fin_i) m_ending = 1;
            m_age++;
        end else if (elig != '0) begin
            for (int i = N - 1; i >= 0; i--) if (elig[i]) m_line = i;
            m_active = 1;
            m_age    = 0;
            m_mcause = 32'h8000_0000 | 32'(m_line);
        end
        m_pend = (m_pend & ~clr) | rise;
        m_prev = irq_req_i;
    endtask

    function automatic logic exp_irq();
        return m_active && !m_ending && (m_age == 0);
    endfunction

    function automatic logic [N-1:0] exp_ack();
        return m_ending ? (N'(1) << m_line) : '0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Inputs are driven at the falling edge; outputs are sampled at the next one.
    task automatic apply(input logic [N-1:0] req, input logic [31:0] mie, input logic fin);
        irq_req_i = req;
        mie_i     = mie;
        irq_fin_i = fin;
        model_edge();
        @(posedge clk_i);
        @(negedge clk_i);
        check("model_irq_o", {31'b0, irq_o}, {31'b0, exp_irq()});
        check("model_mcause_o", mcause_o, m_mcause);
        check("model_irq_ack_o", {16'b0, irq_ack_o}, {16'b0, exp_ack()});
    endtask

    task automatic do_reset();
        irq_req_i = '0;
        mie_i     = '0;
        irq_fin_i = 1'b0;
        rst_ni    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [31:0]  mie;
        logic         fin;
        logic         irq;
        logic [N-1:0] ack;
        logic [31:0]  mcause;
    } vec_t;

    vec_t vt[14];
    int   pulses;

    initial begin
        model_reset();
        repeat (3) @(negedge clk_i);
        check("reset_irq_o", {31'b0, irq_o}, 32'h0);
        check("reset_mcause_o", mcause_o, 32'h0);
        check("reset_irq_ack_o", {16'b0, irq_ack_o}, 32'h0);
        rst_ni = 1'b1;

        // Two-line priority walk, fin in ENTER and IDLE, masked pending, mie drop mid-service.
        vt[0]  = '{16'h0028, 32'hFF, 1'b0, 1'b1, 16'h0000, 32'h8000_0003};
        vt[1]  = '{16'h0028, 32'hFF, 1'b0, 1'b0, 16'h0000, 32'h8000_0003};
        vt[2]  = '{16'h0028, 32'hFF, 1'b1, 1'b0, 16'h0008, 32'h8000_0003};
        vt[3]  = '{16'h0020, 32'hFF, 1'b0, 1'b0, 16'h0000, 32'h8000_0003};
        vt[4]  = '{16'h0020, 32'hFF, 1'b0, 1'b1, 16'h0000, 32'h8000_0005};
        vt[5]  = '{16'h0020, 32'hFF, 1'b1, 1'b0, 16'h0000, 32'h8000_0005};
        vt[6]  = '{16'h0020, 32'hFF, 1'b1, 1'b0, 16'h0020, 32'h8000_0005};
        vt[7]  = '{16'h0000, 32'hFF, 1'b1, 1'b0, 16'h0000, 32'h8000_0005};
        vt[8]  = '{16'h0000, 32'hFF, 1'b1, 1'b0, 16'h0000, 32'h8000_0005};
        vt[9]  = '{16'h0040, 32'h0F, 1'b0, 1'b0, 16'h0000, 32'h8000_0005};
        vt[10] = '{16'h0040, 32'h4F, 1'b0, 1'b1, 16'h0000, 32'h8000_0006};
        vt[11] = '{16'h0040, 32'h00, 1'b0, 1'b0, 16'h0000, 32'h8000_0006};
        vt[12] = '{16'h0040, 32'h00, 1'b1, 1'b0, 16'h0040, 32'h8000_0006};
        vt[13] = '{16'h0000, 32'h00, 1'b0, 1'b0, 16'h0000, 32'h8000_0006};
        foreach (vt[i]) begin
            apply(vt[i].req, vt[i].mie, vt[i].fin);
            check($sformatf("vec%0d_irq_o", i), {31'b0, irq_o}, {31'b0, vt[i].irq});
            check($sformatf("vec%0d_irq_ack_o", i), {16'b0, irq_ack_o}, {16'b0, vt[i].ack});
            check($sformatf("vec%0d_mcause_o", i), mcause_o, vt[i].mcause);
            $display("vec %0d req=0x%04h mie=0x%02h fin=%0b -> irq=%0b ack=0x%04h mcause=0x%08h",
                     i, vt[i].req, vt[i].mie, vt[i].fin, irq_o, irq_ack_o, mcause_o);
        end

        // Line 2 raised at edge 10 after reset.
        do_reset();
        repeat (9) apply(16'h0, 32'h4, 1'b0);
        apply(16'h4, 32'h4, 1'b0);
        check("l2_entry_irq_o", {31'b0, irq_o}, 32'h1);
        check("l2_entry_mcause_o", mcause_o, 32'h8000_0002);
        apply(16'h4, 32'h4, 1'b0);
        check("l2_busy_irq_o", {31'b0, irq_o}, 32'h0);
        apply(16'h4, 32'h4, 1'b1);
        check("l2_exit_ack", {16'b0, irq_ack_o}, 32'h4);
        apply(16'h0, 32'h4, 1'b0);
        $display("seq line2 entry/exit done");

        // Masked line held for 20 cycles, then enabled.
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            apply(16'h1, 32'h0, 1'b0);
            if (irq_o) pulses++;
        end
        check("masked_pulses", 32'(pulses), 32'h0);
        apply(16'h1, 32'h1, 1'b0);
        check("unmask_irq_o", {31'b0, irq_o}, 32'h1);
        check("unmask_mcause_o", mcause_o, 32'h8000_0000);
        apply(16'h1, 32'h1, 1'b0);
        check("unmask_next_irq_o", {31'b0, irq_o}, 32'h0);
        apply(16'h1, 32'h1, 1'b1);
        check("unmask_ack", {16'b0, irq_ack_o}, 32'h1);
        apply(16'h0, 32'h1, 1'b0);
        $display("seq masked line retained then serviced");

        // fin in IDLE is ignored; line 1 raised while line 0 is busy waits for EXIT.
        apply(16'h0, 32'h3, 1'b1);
        apply(16'h0, 32'h3, 1'b1);
        check("idle_fin_ack", {16'b0, irq_ack_o}, 32'h0);
        apply(16'h1, 32'h3, 1'b0);
        apply(16'h1, 32'h3, 1'b0);
        apply(16'h3, 32'h3, 1'b0);
        check("nest_busy_irq_o", {31'b0, irq_o}, 32'h0);
        apply(16'h3, 32'h3, 1'b0);
        apply(16'h2, 32'h3, 1'b1);
        check("nest_l0_ack", {16'b0, irq_ack_o}, 32'h1);
        apply(16'h2, 32'h3, 1'b0);
        check("nest_idle_irq_o", {31'b0, irq_o}, 32'h0);
        apply(16'h2, 32'h3, 1'b0);
        check("nest_l1_irq_o", {31'b0, irq_o}, 32'h1);
        check("nest_l1_mcause_o", mcause_o, 32'h8000_0001);
        apply(16'h2, 32'h3, 1'b0);
        apply(16'h2, 32'h3, 1'b1);
        check("nest_l1_ack", {16'b0, irq_ack_o}, 32'h2);
        apply(16'h0, 32'h3, 1'b0);
        $display("seq fin-in-idle and no nesting done");

        // Asynchronous reset in the middle of BUSY.
        apply(16'h1, 32'h1, 1'b0);
        apply(16'h1, 32'h1, 1'b0);
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        check("midreset_irq_o", {31'b0, irq_o}, 32'h0);
        check("midreset_mcause_o", mcause_o, 32'h0);
        check("midreset_ack", {16'b0, irq_ack_o}, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply(16'h0, 32'h1, 1'b1);
            check("postreset_ack", {16'b0, irq_ack_o}, 32'h0);
        end
        $display("seq reset mid-busy done");

        // Line 0 held high across a whole service.
        pulses = 0;
        apply(16'h1, 32'h1, 1'b0);
        if (irq_o) pulses++;
        apply(16'h1, 32'h1, 1'b0);
        if (irq_o) pulses++;
        apply(16'h1, 32'h1, 1'b1);
        check("hold_exit_ack", {16'b0, irq_ack_o}, 32'h1);
        for (int i = 0; i < 6; i++) begin
            apply(16'h1, 32'h1, 1'b0);
            if (irq_o) pulses++;
        end
`ifdef IRQ_EDGE_EN
        check("hold_pulses", 32'(pulses), 32'h1);
`else
        check("hold_pulses", 32'(pulses), 32'h2);
`endif
        apply(16'h0, 32'h1, 1'b0);
        if (irq_o) pulses++;
        apply(16'h1, 32'h1, 1'b0);
        if (irq_o) pulses++;
        check("reedge_pulses", 32'(pulses), 32'h2);
        repeat (4) apply(16'h0, 32'h1, 1'b1);
        $display("seq held line pulses=%0d", pulses);

        // Randomized traffic against the model.
        do_reset();
        begin
            logic [N-1:0] req;
            logic [31:0]  mie;
            req = '0;
            mie = 32'hFFFF;
            for (int c = 0; c < 800; c++) begin
                for (int b = 0; b < N; b++)
                    if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
                if ($urandom_range(0, 49) == 0) mie = $urandom();
                apply(req, mie, ($urandom_range(0, 3) == 0));
                if (irq_ack_o != '0)
                    $display("rand cycle %0d ack=0x%04h mcause=0x%08h", c, irq_ack_o, mcause_o);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
